// File: rtl/mem_copy_pkg.sv
// mem_copy_pkg
// Shared definitions for the memory copy engine: the controller state
// encoding, the default legal memory window and the default address stride.
// No ports; imported with `import mem_copy_pkg::*;`.
package mem_copy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Default legal data-memory window, both ends inclusive.
  localparam int MEM_BASE_DEFAULT  = 1024;
  localparam int MEM_LIMIT_DEFAULT = 1280;

  // Default byte increment between consecutive 32-bit words.
  localparam int STRIDE_DEFAULT = 4;

endpackage : mem_copy_pkg

// File: rtl/mem_copy_engine_if.sv
// mem_copy_engine_if
// Bundles the request/status handshake and the data-memory bus of the copy
// engine.
//   start, srcAddr, dstAddr, count : copy request (initiator -> engine)
//   busy, done, error              : status (engine -> initiator)
//   memWrite, address, wdata       : memory bus driven by the engine
//   rdata                          : combinational memory read data
// Modports: slave = copy engine, master = requester / memory side.
interface mem_copy_engine_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 9
);

  logic              start;
  logic [ADDR_W-1:0] srcAddr;
  logic [ADDR_W-1:0] dstAddr;
  logic [CNT_W-1:0]  count;
  logic              busy;
  logic              done;
  logic              error;
  logic              memWrite;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport slave (
    input  start, srcAddr, dstAddr, count, rdata,
    output busy, done, error, memWrite, address, wdata
  );

  modport master (
    output start, srcAddr, dstAddr, count, rdata,
    input  busy, done, error, memWrite, address, wdata
  );

endinterface : mem_copy_engine_if

// File: rtl/mem_range_check.sv
// mem_range_check
// Combinational window comparator used when MEM_COPY_BOUNDS_CHECK_EN is
// defined.
//   address : byte address under test
//   inRange : 1 when MEM_BASE <= address <= MEM_LIMIT
module mem_range_check
  import mem_copy_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_BASE  = MEM_BASE_DEFAULT,
  parameter int MEM_LIMIT = MEM_LIMIT_DEFAULT
) (
  input  logic [ADDR_W-1:0] address,
  output logic              inRange
);

  assign inRange = (address >= ADDR_W'(MEM_BASE)) &&
                   (address <= ADDR_W'(MEM_LIMIT));

endmodule : mem_range_check

// File: rtl/mem_copy_engine.sv
// mem_copy_engine
// Small DMA helper that copies `count` 32-bit words from srcAddr to dstAddr,
// one READ cycle and one WRITE cycle per word, then pulses done. It owns the
// data-memory port only while busy is high; an external mux uses busy to
// choose between the CPU and this block.
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : mem_copy_engine_if.slave (request, status and memory bus)
// Build option: define MEM_COPY_BOUNDS_CHECK_EN to check every READ/WRITE
// address against [MEM_BASE, MEM_LIMIT]; a violation suppresses the write,
// ends the transfer and sets error until the next accepted start. Without
// the macro, error is tied to 0.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 9,
`ifdef MEM_COPY_BOUNDS_CHECK_EN
  parameter int MEM_BASE  = MEM_BASE_DEFAULT,
  parameter int MEM_LIMIT = MEM_LIMIT_DEFAULT,
`endif
  parameter int STRIDE    = STRIDE_DEFAULT
) (
  input logic              clock,
  input logic              reset,
  mem_copy_engine_if.slave bus
);

  state_t            state;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [ADDR_W-1:0] address_q;
  logic [DATA_W-1:0] word_buf;     // doubles as the wdata register
  logic [CNT_W-1:0]  remaining;
  logic              busy_q;
  logic              done_q;
  logic              mem_write_q;
  logic              error_q;
  logic              addr_ok;

  // Word-aligned versions of the requested start addresses.
  logic [ADDR_W-1:0] src_aligned;
  logic [ADDR_W-1:0] dst_aligned;
  assign src_aligned = {bus.srcAddr[ADDR_W-1:2], 2'b00};
  assign dst_aligned = {bus.dstAddr[ADDR_W-1:2], 2'b00};

`ifdef MEM_COPY_BOUNDS_CHECK_EN
  logic in_range;

  // address_q is the live bus address, so checking it covers both the
  // source pointer in READ and the destination pointer in WRITE.
  mem_range_check #(
    .ADDR_W    (ADDR_W),
    .MEM_BASE  (MEM_BASE),
    .MEM_LIMIT (MEM_LIMIT)
  ) u_range_check (
    .address (address_q),
    .inRange (in_range)
  );

  assign addr_ok = in_range || (state == ST_IDLE) || (state == ST_DONE);
`else
  assign addr_ok = 1'b1;
`endif

  always_ff @(posedge clock) begin
    // NOTE: every state register here uses <= so all of them update from the
    // same pre-edge values; a blocking = would let later lines see new values.
    if (reset) begin
      state       <= ST_IDLE;
      src_ptr     <= '0;
      dst_ptr     <= '0;
      address_q   <= '0;
      word_buf    <= '0;
      remaining   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_write_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            src_ptr   <= src_aligned;
            dst_ptr   <= dst_aligned;
            remaining <= bus.count;
            error_q   <= 1'b0;
            busy_q    <= 1'b1;
            if (bus.count == '0) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end else begin
              state     <= ST_READ;
              address_q <= src_aligned;
            end
          end
        end

        ST_READ: begin
          if (!addr_ok) begin
            state   <= ST_DONE;
            done_q  <= 1'b1;
            error_q <= 1'b1;
          end else begin
            word_buf    <= bus.rdata;
            address_q   <= dst_ptr;
            mem_write_q <= 1'b1;
            state       <= ST_WRITE;
          end
        end

        ST_WRITE: begin
          mem_write_q <= 1'b0;
          if (!addr_ok) begin
            state   <= ST_DONE;
            done_q  <= 1'b1;
            error_q <= 1'b1;
          end else begin
            src_ptr   <= src_ptr + ADDR_W'(STRIDE);
            dst_ptr   <= dst_ptr + ADDR_W'(STRIDE);
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end else begin
              state     <= ST_READ;
              address_q <= src_ptr + ADDR_W'(STRIDE);
            end
          end
        end

        ST_DONE: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.address = address_q;
  assign bus.wdata   = word_buf;
  // An out-of-window WRITE address must never reach memory, so the
  // registered enable is qualified by the live range check.
  assign bus.memWrite = mem_write_q & addr_ok;

`ifdef MEM_COPY_BOUNDS_CHECK_EN
  assign bus.error = error_q;
`else
  assign bus.error = 1'b0;
`endif

endmodule : mem_copy_engine
